// File: rtl/input_port_router_pkg.sv
// Shared router definitions: network widths, port indices used by the
// output port arbiters, ingress FSM states and the queued packet layout.
package input_port_router_pkg;

    localparam int NETWORK_ADDRESS_WIDTH    = 4;
    localparam int CACHE_BANK_ADDRESS_WIDTH = 2;
    localparam int DATA_WIDTH               = 16;
    localparam int COORD_WIDTH              = NETWORK_ADDRESS_WIDTH / 2;
    localparam int DEST_WIDTH               = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;

    localparam int PORT_N     = 0;
    localparam int PORT_S     = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_W     = 3;
    localparam int PORT_LOCAL = 4;
    localparam int NUM_PORTS  = 5;

    typedef enum logic [1:0] {
        EMPTY,
        ISSUE,
        BLOCKED
    } issueState_t;

    typedef struct packed {
        logic                             read;
        logic                             write;
        logic [DEST_WIDTH-1:0]            destinationAddress;
        logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddress;
        logic [DATA_WIDTH-1:0]            data;
    } packet_t;

endpackage

// File: rtl/input_port_router_if.sv
// Link-side and arbiter-side signals of one router input port.
interface input_port_router_if;
    import input_port_router_pkg::*;

    logic                             readIn;
    logic                             writeIn;
    logic [DEST_WIDTH-1:0]            destinationAddressIn;
    logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressIn;
    logic [DATA_WIDTH-1:0]            dataIn;
    logic [NUM_PORTS-1:0]             stallIn;

    logic                             portReady;
    logic                             selectBit_NORTH;
    logic                             selectBit_SOUTH;
    logic                             selectBit_EAST;
    logic                             selectBit_WEST;
    logic                             selectBit_LOCAL;
    logic [DEST_WIDTH-1:0]            destinationAddressOut;
    logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressOut;
    logic                             readOut;
    logic                             writeOut;
    logic [DATA_WIDTH-1:0]            dataOut;
    logic                             malformedPulse;

    modport master (
        output readIn, writeIn, destinationAddressIn, requesterAddressIn, dataIn, stallIn,
        input  portReady, selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST,
               selectBit_LOCAL, destinationAddressOut, requesterAddressOut, readOut, writeOut,
               dataOut, malformedPulse
    );

    modport slave (
        input  readIn, writeIn, destinationAddressIn, requesterAddressIn, dataIn, stallIn,
        output portReady, selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST,
               selectBit_LOCAL, destinationAddressOut, requesterAddressOut, readOut, writeOut,
               dataOut, malformedPulse
    );

endinterface

// File: rtl/input_port_router_xy_route_compute.sv
// XY dimension-ordered route: resolve X first, then Y, else deliver locally.
module xy_route_compute
    import input_port_router_pkg::*;
#(
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic [NETWORK_ADDRESS_WIDTH-1:0] networkAddress,
    output logic [NUM_PORTS-1:0]             route
);

    localparam logic [COORD_WIDTH-1:0] localX = COORD_WIDTH'(LOCAL_X);
    localparam logic [COORD_WIDTH-1:0] localY = COORD_WIDTH'(LOCAL_Y);

    logic [COORD_WIDTH-1:0] destX;
    logic [COORD_WIDTH-1:0] destY;

    assign destX = networkAddress[NETWORK_ADDRESS_WIDTH-1 -: COORD_WIDTH];
    assign destY = networkAddress[COORD_WIDTH-1:0];

    always_comb begin
        route = '0;
        if (destX > localX)
            route[PORT_E] = 1'b1;
        else if (destX < localX)
            route[PORT_W] = 1'b1;
        else if (destY > localY)
            route[PORT_N] = 1'b1;
        else if (destY < localY)
            route[PORT_S] = 1'b1;
        else
            route[PORT_LOCAL] = 1'b1;
    end

endmodule

// File: rtl/input_port_router.sv
// Router ingress stage: FIFO of incoming packets, XY route of the head packet,
// and an in-order issue FSM that honours per-target stall.
module input_port_router
    import input_port_router_pkg::*;
#(
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                reset,
    input_port_router_if.slave port
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    packet_t              fifoMem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wp;
    logic [PTR_WIDTH-1:0] rp;
    logic [PTR_WIDTH:0]   count;
    logic [PTR_WIDTH:0]   nextCount;
    issueState_t          state;
    issueState_t          nextState;

    packet_t              incoming;
    packet_t              head;
    packet_t              outPacket;
    logic [NUM_PORTS-1:0] headRoute;
    logic [NUM_PORTS-1:0] selectReg;
    logic                 ready;
    logic                 push;
    logic                 pop;
    logic                 malformed;
    logic                 targetStalled;
    logic                 malformedReg;

    assign ready     = (count < (PTR_WIDTH+1)'(FIFO_DEPTH));
    assign malformed = port.readIn & port.writeIn;
    assign push      = (port.readIn ^ port.writeIn) & ready;
    assign nextCount = count + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);

    assign incoming.read               = port.readIn;
    assign incoming.write              = port.writeIn;
    assign incoming.destinationAddress = port.destinationAddressIn;
    assign incoming.requesterAddress   = port.requesterAddressIn;
    assign incoming.data               = port.dataIn;

    assign head = fifoMem[rp];

    xy_route_compute #(
        .LOCAL_X (LOCAL_X),
        .LOCAL_Y (LOCAL_Y)
    ) routeCompute (
        .networkAddress (head.destinationAddress[DEST_WIDTH-1 -: NETWORK_ADDRESS_WIDTH]),
        .route          (headRoute)
    );

    assign targetStalled = |(headRoute & port.stallIn);

    // EMPTY moves on the push itself so the head can issue on the very next edge.
    always_comb begin
        nextState = state;
        pop       = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push)
                    nextState = ISSUE;
            end
            ISSUE: begin
                if (targetStalled) begin
                    nextState = BLOCKED;
                end else begin
                    pop = 1'b1;
                    if (count == (PTR_WIDTH+1)'(1) && !push)
                        nextState = EMPTY;
                end
            end
            BLOCKED: begin
                if (!targetStalled)
                    nextState = ISSUE;
            end
            default: nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            state <= nextState;
            count <= nextCount;
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifoMem[wp] <= incoming;
    end

    // Payload fields hold between issues; only the strobes drop back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            selectReg    <= '0;
            outPacket    <= '0;
            malformedReg <= 1'b0;
        end else begin
            malformedReg <= malformed;
            if (pop) begin
                selectReg <= headRoute;
                outPacket <= head;
            end else begin
                selectReg       <= '0;
                outPacket.read  <= 1'b0;
                outPacket.write <= 1'b0;
            end
        end
    end

    assign port.portReady             = ready;
    assign port.selectBit_NORTH       = selectReg[PORT_N];
    assign port.selectBit_SOUTH       = selectReg[PORT_S];
    assign port.selectBit_EAST        = selectReg[PORT_E];
    assign port.selectBit_WEST        = selectReg[PORT_W];
    assign port.selectBit_LOCAL       = selectReg[PORT_LOCAL];
    assign port.readOut               = outPacket.read;
    assign port.writeOut              = outPacket.write;
    assign port.destinationAddressOut = outPacket.destinationAddress;
    assign port.requesterAddressOut   = outPacket.requesterAddress;
    assign port.dataOut               = outPacket.data;
    assign port.malformedPulse        = malformedReg;

endmodule
